cpu_sequential: RTL and testbench

Single-cycle (sequential, non-pipelined) RV64 integer CPU executing a subset of RV64I: add, sub, and, or, addi, ld, sd, beq. It is the top-level datapath: it contains the instruction memory, register file, ALU, control unit and data memory, and executes one instruction per clock. Benches load programs and inspect state through fixed hierarchical names.

---
 rtl/cpu_sequential.sv | 245 ++++++++++++++++++++++++
 tb/tb_cpu_sequential.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequential.sv
// Single-cycle RV64I subset CPU: add, sub, and, or, addi, ld, sd, beq.
// Fetch, decode, execute, memory and writeback all complete in one clock.

module cpu_imem (
    input  logic        clk,
    input  logic        load_en,
    input  logic [5:0]  load_addr,
    input  logic [31:0] load_data,
    input  logic [5:0]  addr,
    output logic [31:0] data
);
    logic [31:0] memory [0:63];

    // Preload port; the CPU ties it off and never writes program memory.
    always_ff @(posedge clk) begin
        if (load_en)
            memory[load_addr] <= load_data;
    end

    assign data = memory[addr];
endmodule

module cpu_reg_file (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic        we,
    input  logic [63:0] wdata,
    output logic [63:0] rdata1,
    output logic [63:0] rdata2
);
    logic [63:0] registers [0:31];

    // Clear on reset; commit writeback at the edge, x0 stays zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                registers[i] <= '0;
        end else if (we && rd != 5'd0) begin
            registers[rd] <= wdata;
        end
    end

    assign rdata1 = (rs1 == 5'd0) ? 64'd0 : registers[rs1];
    assign rdata2 = (rs2 == 5'd0) ? 64'd0 : registers[rs2];
endmodule

module cpu_dmem (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  addr,
    input  logic        we,
    input  logic [63:0] wdata,
    output logic [63:0] rdata
);
    logic [63:0] memory [0:31];

    // Clear on reset; doubleword store at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++)
                memory[i] <= '0;
        end else if (we) begin
            memory[addr] <= wdata;
        end
    end

    assign rdata = memory[addr];
endmodule

module cpu_sequential (
    input logic clk,
    input logic reset
);
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_SD = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    logic [63:0] pc_current;
    logic [63:0] pc_next;
    logic [31:0] instruction;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opcode;
    logic [2:0]  funct3;

    logic        branch;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_write;
    logic [1:0]  alu_op;

    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] reg_read_data1;
    logic [63:0] reg_read_data2;
    logic [63:0] alu_b;
    logic [63:0] alu_result;
    logic        zero;
    logic [63:0] mem_read_data;
    logic [63:0] reg_write_data;

    cpu_imem imem (
        .clk       (clk),
        .load_en   (1'b0),
        .load_addr (6'd0),
        .load_data (32'd0),
        .addr      (pc_current[7:2]),
        .data      (instruction)
    );

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign rd     = instruction[11:7];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];

    assign imm_i = {{52{instruction[31]}}, instruction[31:20]};
    assign imm_s = {{52{instruction[31]}}, instruction[31:25],
                    instruction[11:7]};
    assign imm_b = {{51{instruction[31]}}, instruction[31],
                    instruction[7], instruction[30:25],
                    instruction[11:8], 1'b0};

    // Main decoder; unsupported opcode/funct3 pairs fall out as NOPs.
    always_comb begin
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_R: begin
                case (funct3)
                    3'b000: begin
                        reg_write = 1'b1;
                        alu_op = instruction[30] ? ALU_SUB : ALU_ADD;
                    end
                    3'b111: begin
                        reg_write = 1'b1;
                        alu_op = ALU_AND;
                    end
                    3'b110: begin
                        reg_write = 1'b1;
                        alu_op = ALU_OR;
                    end
                    default: ;
                endcase
            end
            OP_I: begin
                if (funct3 == 3'b000) begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
            end
            OP_LD: begin
                if (funct3 == 3'b011) begin
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    alu_src    = 1'b1;
                    reg_write  = 1'b1;
                end
            end
            OP_SD: begin
                if (funct3 == 3'b011) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                end
            end
            OP_BR: begin
                if (funct3 == 3'b000) begin
                    branch = 1'b1;
                    alu_op = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

    cpu_reg_file reg_file (
        .clk    (clk),
        .reset  (reset),
        .rs1    (rs1),
        .rs2    (rs2),
        .rd     (rd),
        .we     (reg_write),
        .wdata  (reg_write_data),
        .rdata1 (reg_read_data1),
        .rdata2 (reg_read_data2)
    );

    assign alu_b = !alu_src  ? reg_read_data2 :
                   mem_write ? imm_s : imm_i;

    // ALU; arithmetic wraps modulo 2^64.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = reg_read_data1 + alu_b;
            ALU_SUB: alu_result = reg_read_data1 - alu_b;
            ALU_AND: alu_result = reg_read_data1 & alu_b;
            ALU_OR:  alu_result = reg_read_data1 | alu_b;
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == 64'd0);

    cpu_dmem dmem (
        .clk   (clk),
        .reset (reset),
        .addr  (alu_result[7:3]),
        .we    (mem_write),
        .wdata (reg_read_data2),
        .rdata (mem_read_data)
    );

    assign reg_write_data = mem_to_reg ? mem_read_data : alu_result;

    assign pc_next = (branch && zero) ? pc_current + imm_b
                                      : pc_current + 64'd4;

    // Program counter; reset restarts fetch at address zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc_current <= '0;
        else
            pc_current <= pc_next;
    end
endmodule

// File: tb/tb_cpu_sequential.sv
// Scoreboard bench for cpu_sequential: programs are preloaded into imem,
// expectations are queued and compared against architectural state.

module tb_cpu_sequential;
    logic clk;
    logic reset;

    cpu_sequential dut (
        .clk   (clk),
        .reset (reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int K_PC   = 0;
    localparam int K_REG  = 1;
    localparam int K_MEM  = 2;
    localparam int K_MRD  = 3;
    localparam int K_INST = 4;

    typedef struct {
        int          kind;
        int          idx;
        logic [63:0] exp;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic push(input int kind, input int idx,
                        input logic [63:0] exp, input string tag);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] observe(input int kind, input int idx);
        case (kind)
            K_PC:    return dut.pc_current;
            K_REG:   return dut.reg_file.registers[idx];
            K_MEM:   return dut.dmem.memory[idx];
            K_MRD:   return {63'd0, dut.mem_read};
            K_INST:  return {32'd0, dut.instruction};
            default: return 64'hdead;
        endcase
    endfunction

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.kind, e.idx), e.exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [6:0] f7,
        input int rs2, input int rs1, input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1,
                                         input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] ld(input int rd, input int imm,
                                       input int rs1);
        return {12'(imm), 5'(rs1), 3'b011, 5'(rd), 7'b0000011};
    endfunction

    function automatic logic [31:0] sd(input int rs2, input int imm,
                                       input int rs1);
        logic [11:0] m;
        m = 12'(imm);
        return {m[11:5], 5'(rs2), 5'(rs1), 3'b011, m[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] beq(input int rs1, input int rs2,
                                        input int imm);
        logic [12:0] b;
        b = 13'(imm);
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'b000,
                b[4:1], b[11], 7'b1100011};
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic clear_prog();
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 64; i++)
            dut.imem.memory[i] = 32'd0;
    endtask

    task automatic put(input int a, input logic [31:0] w);
        dut.imem.memory[a] = w;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    logic [31:0] loop_prog [12];
    int          n;

    initial begin
        reset = 1'b0;
        loop_prog = '{32'h00500093, 32'h00200113, 32'h000001b3,
                      32'h02008063, 32'h00010213, 32'h00020863,
                      32'h001181b3, 32'hfff20213, 32'hfe000ae3,
                      32'hfff08093, 32'hfe0002e3, 32'h00000000};

        // Reset state with the loop program loaded.
        clear_prog();
        for (int i = 0; i < 12; i++)
            put(i, loop_prog[i]);
        #1;
        push(K_PC, 0, 64'd0, "rst_pc");
        push(K_INST, 0, 64'h00500093, "rst_instr");
        push(K_REG, 3, 64'd0, "rst_x3");
        push(K_MEM, 3, 64'd0, "rst_dmem3");
        drain();

        // Nested loop program, run until the zero word is fetched.
        release_reset();
        n = 0;
        while (dut.instruction != 32'd0 && n < 400) begin
            tick(1);
            n++;
        end
        check("loop_done", {63'd0, dut.instruction == 32'd0}, 64'd1);
        push(K_PC, 0, 64'h2c, "loop_pc");
        push(K_REG, 1, 64'd0, "loop_x1");
        push(K_REG, 2, 64'd2, "loop_x2");
        push(K_REG, 3, 64'd30, "loop_x3");
        push(K_REG, 4, 64'd0, "loop_x4");
        for (int i = 5; i < 32; i++)
            push(K_REG, i, 64'd0, $sformatf("loop_x%0d", i));
        drain();

        // Store then load through the same base register.
        clear_prog();
        put(0, addi(5, 0, 42));
        put(1, addi(6, 0, 16));
        put(2, sd(5, 8, 6));
        put(3, ld(7, 8, 6));
        release_reset();
        for (int k = 0; k < 5; k++) begin
            push(K_MRD, 0, (k == 3) ? 64'd1 : 64'd0,
                 $sformatf("mem_read_%0d", k));
            drain();
            if (k < 4)
                tick(1);
        end
        push(K_MEM, 3, 64'd42, "mem_dmem3");
        push(K_MEM, 2, 64'd0, "mem_dmem2");
        push(K_REG, 7, 64'd42, "mem_x7");
        push(K_PC, 0, 64'h10, "mem_pc");
        drain();

        // ALU ops, x0 write discard and both branch directions.
        clear_prog();
        put(0, addi(1, 0, 12));
        put(1, addi(2, 0, 10));
        put(2, r_op(7'h00, 2, 1, 3'b000, 3));
        put(3, r_op(7'h20, 2, 1, 3'b000, 4));
        put(4, r_op(7'h00, 2, 1, 3'b111, 5));
        put(5, r_op(7'h00, 2, 1, 3'b110, 6));
        put(6, r_op(7'h20, 1, 2, 3'b000, 7));
        put(7, addi(0, 0, 5));
        put(8, beq(1, 2, 16));
        put(9, beq(0, 0, -8));
        release_reset();
        tick(8);
        push(K_REG, 3, 64'd22, "alu_add");
        push(K_REG, 4, 64'd2, "alu_sub");
        push(K_REG, 5, 64'd8, "alu_and");
        push(K_REG, 6, 64'd14, "alu_or");
        push(K_REG, 7, 64'hFFFFFFFFFFFFFFFE, "alu_sub_neg");
        push(K_REG, 0, 64'd0, "x0_zero");
        push(K_PC, 0, 64'h20, "alu_pc");
        drain();
        tick(1);
        push(K_PC, 0, 64'h24, "beq_not_taken");
        drain();
        tick(1);
        push(K_PC, 0, 64'h1c, "beq_back");
        drain();

        // NOPs, then an asynchronous reset in the middle of the run.
        clear_prog();
        put(0, addi(5, 0, 42));
        put(1, sd(5, 24, 0));
        put(2, addi(3, 0, 7));
        release_reset();
        tick(3);
        push(K_PC, 0, 64'hc, "pre_pc");
        push(K_REG, 3, 64'd7, "pre_x3");
        push(K_MEM, 3, 64'd42, "pre_dmem3");
        drain();
        tick(2);
        push(K_PC, 0, 64'h14, "nop_pc");
        push(K_REG, 3, 64'd7, "nop_x3");
        push(K_REG, 5, 64'd42, "nop_x5");
        push(K_MEM, 3, 64'd42, "nop_dmem3");
        drain();
        reset = 1'b0;
        #1;
        push(K_PC, 0, 64'd0, "arst_pc");
        for (int i = 0; i < 32; i++)
            push(K_REG, i, 64'd0, $sformatf("arst_x%0d", i));
        for (int i = 0; i < 32; i++)
            push(K_MEM, i, 64'd0, $sformatf("arst_dmem%0d", i));
        drain();
        tick(2);
        push(K_PC, 0, 64'd0, "hold_pc");
        push(K_REG, 5, 64'd0, "hold_x5");
        drain();
        reset = 1'b1;
        tick(1);
        push(K_PC, 0, 64'd4, "restart_pc");
        push(K_REG, 5, 64'd42, "restart_x5");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
